// File: rtl/add_sub_serial_nbit_if.sv
// Operand/result handshake bundle for the slice-serial add/sub unit.
// master drives operands and Out_Ready; slave returns Sum and Z/N/C/V flags.
interface add_sub_serial_nbit_if #(
  parameter int WIDTH = 8
);
  logic             In_Valid;
  logic             In_Ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Cin;
  logic             Binv;
  logic             Out_Valid;
  logic             Out_Ready;
  logic [WIDTH-1:0] Sum;
  logic             Cout;
  logic             Zero;
  logic             Neg;
  logic             Ovf;

  modport master (
    output In_Valid, A, B, Cin, Binv, Out_Ready,
    input  In_Ready, Out_Valid, Sum, Cout, Zero, Neg, Ovf
  );

  modport slave (
    input  In_Valid, A, B, Cin, Binv, Out_Ready,
    output In_Ready, Out_Valid, Sum, Cout, Zero, Neg, Ovf
  );
endinterface

// File: rtl/add_sub_serial_nbit.sv
// N-bit add/sub, CHUNK bits per clock LSB first, registered inter-slice carry.
// Ports: Clk, Reset (sync, high), bus = slave side of add_sub_serial_nbit_if.
module add_sub_serial_nbit #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 4
) (
  input logic                  Clk,
  input logic                  Reset,
  add_sub_serial_nbit_if.slave bus
);
  localparam int K  = WIDTH / CHUNK;
  localparam int CW = (K > 1) ? $clog2(K) : 1;
  localparam logic [CW-1:0] KLAST = CW'(K - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic [WIDTH-1:0] a_q, b_q;
  logic [WIDTH-1:0] res_q, res_d;
  logic [CW-1:0]    k_q;
  logic             c_q;
  logic [CHUNK-1:0] a_sl, b_sl, s_sl;
  logic             c_out, c_msb, last;
  logic             cout_q, zero_q, neg_q, ovf_q;

  // Operands shift right each slice, so the live slice is always bit 0.
  assign a_sl = a_q[CHUNK-1:0];
  assign b_sl = b_q[CHUNK-1:0];

  assign {c_out, s_sl} = {1'b0, a_sl}
                       + {1'b0, b_sl}
                       + {{CHUNK{1'b0}}, c_q};

  // Carry into the slice MSB, recovered from its sum bit.
  assign c_msb = s_sl[CHUNK-1]
               ^ a_sl[CHUNK-1]
               ^ b_sl[CHUNK-1];

  // Result fills from the top; after K slices it is aligned.
  assign res_d = (res_q >> CHUNK)
               | (WIDTH'(s_sl) << (WIDTH - CHUNK));

  assign last = (k_q == KLAST);

  assign bus.In_Ready  = (state_q == IDLE);
  assign bus.Out_Valid = (state_q == DONE);
  assign bus.Sum       = res_q;
  assign bus.Cout      = cout_q;
  assign bus.Zero      = zero_q;
  assign bus.Neg       = neg_q;
  assign bus.Ovf       = ovf_q;

  always_ff @(posedge Clk) begin
    if (Reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.In_Valid)  state_d = RUN;
      RUN:     if (last)          state_d = DONE;
      DONE:    if (bus.Out_Ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      a_q    <= '0;
      b_q    <= '0;
      res_q  <= '0;
      k_q    <= '0;
      c_q    <= 1'b0;
      cout_q <= 1'b0;
      zero_q <= 1'b0;
      neg_q  <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (state_q == IDLE && bus.In_Valid) begin
      a_q <= bus.A;
      b_q <= bus.B ^ {WIDTH{bus.Binv}};
      c_q <= bus.Cin;
      k_q <= '0;
    end else if (state_q == RUN) begin
      a_q   <= a_q >> CHUNK;
      b_q   <= b_q >> CHUNK;
      c_q   <= c_out;
      res_q <= res_d;
      k_q   <= k_q + 1'b1;
      if (last) begin
        cout_q <= c_out;
        ovf_q  <= c_out ^ c_msb;
        zero_q <= (res_d == '0);
        neg_q  <= res_d[WIDTH-1];
      end
    end
  end
endmodule

// File: tb/tb_add_sub_serial_nbit.sv
// Bench for add_sub_serial_nbit: directed table on 8/4, random on 8/1, 8/8, 16/4.
// Random results are compared against plain-arithmetic add/sub reference.
module tb_add_sub_serial_nbit;
  logic clk;
  logic rst_d;
  logic rst_r;
  logic go_rnd;
  int   total;
  int   bad;
  int   ndone;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  add_sub_serial_nbit_if #(.WIDTH(8)) db();

  add_sub_serial_nbit #(.WIDTH(8), .CHUNK(4)) u_d (
    .Clk   (clk),
    .Reset (rst_d),
    .bus   (db.slave)
  );

  for (genvar g = 0; g < 3; g++) begin : g_rnd
    localparam int W = (g == 2) ? 16 : 8;
    localparam int C = (g == 0) ? 1 : (g == 1) ? 8 : 4;

    add_sub_serial_nbit_if #(.WIDTH(W)) rif();

    add_sub_serial_nbit #(.WIDTH(W), .CHUNK(C)) u_r (
      .Clk   (clk),
      .Reset (rst_r),
      .bus   (rif.slave)
    );

    logic [W-1:0] ra, rbv, bx;
    logic [W:0]   full;
    logic         ci, bi, v;
    int           lat;

    initial begin
      rif.In_Valid  = 1'b0;
      rif.Out_Ready = 1'b1;
      rif.A    = '0;
      rif.B    = '0;
      rif.Cin  = 1'b0;
      rif.Binv = 1'b0;
      wait (go_rnd);
      for (int n = 0; n < 40; n++) begin
        @(negedge clk);
        ra  = W'($urandom);
        rbv = W'($urandom);
        ci  = 1'($urandom);
        bi  = 1'($urandom);
        if (n == 0) begin
          ra = '1; rbv = W'(1); ci = 1'b0; bi = 1'b0;
        end
        if (n == 1) begin
          ra = {1'b0, {(W-1){1'b1}}}; rbv = '1;
          ci = 1'b1; bi = 1'b1;
        end
        check($sformatf("rnd%0d_in_ready", g),
              32'(rif.In_Ready), 32'd1);
        rif.A = ra; rif.B = rbv;
        rif.Cin = ci; rif.Binv = bi;
        rif.In_Valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rif.In_Valid = 1'b0;
        rif.A = ~ra; rif.B = ~rbv;
        rif.Cin = ~ci; rif.Binv = ~bi;
        lat = 0;
        while (!rif.Out_Valid && lat < 100) begin
          @(negedge clk);
          lat++;
        end
        bx   = bi ? ~rbv : rbv;
        full = {1'b0, ra} + {1'b0, bx} + (W+1)'(ci);
        v    = (ra[W-1] == bx[W-1]) && (full[W-1] != ra[W-1]);
        check($sformatf("rnd%0d_latency", g),
              32'(lat), 32'(W / C));
        check($sformatf("rnd%0d_sum", g),
              32'(rif.Sum), 32'(full[W-1:0]));
        check($sformatf("rnd%0d_flags_czno", g),
              32'({rif.Cout, rif.Zero, rif.Neg, rif.Ovf}),
              32'({full[W], full[W-1:0] == '0, full[W-1], v}));
      end
      ndone++;
    end
  end

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       binv;
    logic [7:0] s;
    logic [3:0] f;
  } vec_t;

  vec_t vt[10];

  task automatic op_d(input logic [7:0] a, input logic [7:0] b,
                      input logic cin, input logic binv,
                      output int lat);
    check("d_in_ready_before_op", 32'(db.In_Ready), 32'd1);
    db.A = a; db.B = b; db.Cin = cin; db.Binv = binv;
    db.In_Valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    db.In_Valid = 1'b0;
    db.A = ~a; db.B = ~b; db.Cin = ~cin; db.Binv = ~binv;
    lat = 0;
    while (!db.Out_Valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  int lat;

  initial begin
    total  = 0;
    bad    = 0;
    ndone  = 0;
    go_rnd = 1'b0;
    rst_d  = 1'b1;
    rst_r  = 1'b1;
    db.In_Valid  = 1'b0;
    db.Out_Ready = 1'b1;
    db.A    = '0;
    db.B    = '0;
    db.Cin  = 1'b0;
    db.Binv = 1'b0;

    // {C,Z,N,V} flag order in f
    vt[0] = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 4'b0011};
    vt[1] = '{8'h05, 8'h05, 1'b1, 1'b1, 8'h00, 4'b1100};
    vt[2] = '{8'h03, 8'h05, 1'b1, 1'b1, 8'hFE, 4'b0010};
    vt[3] = '{8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 4'b0000};
    vt[4] = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 4'b1100};
    vt[5] = '{8'h80, 8'h01, 1'b1, 1'b1, 8'h7F, 4'b1001};
    vt[6] = '{8'h12, 8'h34, 1'b0, 1'b0, 8'h46, 4'b0000};
    vt[7] = '{8'h0F, 8'hF0, 1'b1, 1'b0, 8'h00, 4'b1100};
    vt[8] = '{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 4'b1101};
    vt[9] = '{8'h05, 8'h05, 1'b0, 1'b1, 8'hFF, 4'b0010};

    repeat (3) @(negedge clk);
    rst_d = 1'b0;
    rst_r = 1'b0;
    @(negedge clk);
    check("reset_in_ready", 32'(db.In_Ready), 32'd1);
    check("reset_out_valid", 32'(db.Out_Valid), 32'd0);
    check("reset_sum", 32'(db.Sum), 32'd0);
    check("reset_flags",
          32'({db.Cout, db.Zero, db.Neg, db.Ovf}), 32'd0);

    for (int i = 0; i < 10; i++) begin
      op_d(vt[i].a, vt[i].b, vt[i].cin, vt[i].binv, lat);
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'd2);
      check($sformatf("vec%0d_sum", i), 32'(db.Sum), 32'(vt[i].s));
      check($sformatf("vec%0d_flags_czno", i),
            32'({db.Cout, db.Zero, db.Neg, db.Ovf}), 32'(vt[i].f));
      @(negedge clk);
    end

    // Stall in DONE with inputs scrambled during RUN.
    db.Out_Ready = 1'b0;
    op_d(8'h12, 8'h34, 1'b0, 1'b0, lat);
    check("stall_latency", 32'(lat), 32'd2);
    for (int i = 0; i < 5; i++) begin
      db.In_Valid = 1'b1;
      db.A = 8'(i * 37);
      @(negedge clk);
      check("stall_out_valid", 32'(db.Out_Valid), 32'd1);
      check("stall_in_ready", 32'(db.In_Ready), 32'd0);
      check("stall_sum", 32'(db.Sum), 32'h46);
      check("stall_flags",
            32'({db.Cout, db.Zero, db.Neg, db.Ovf}), 32'd0);
    end
    db.In_Valid  = 1'b0;
    db.Out_Ready = 1'b1;
    @(negedge clk);
    check("release_out_valid", 32'(db.Out_Valid), 32'd0);
    check("release_in_ready", 32'(db.In_Ready), 32'd1);
    check("idle_sum_held", 32'(db.Sum), 32'h46);

    // Reset after slice 0 has been written.
    db.A = 8'h55; db.B = 8'h22; db.Cin = 1'b0; db.Binv = 1'b0;
    db.In_Valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    db.In_Valid = 1'b0;
    @(negedge clk);
    rst_d = 1'b1;
    @(negedge clk);
    check("midreset_in_ready", 32'(db.In_Ready), 32'd1);
    check("midreset_out_valid", 32'(db.Out_Valid), 32'd0);
    check("midreset_sum", 32'(db.Sum), 32'd0);
    check("midreset_flags",
          32'({db.Cout, db.Zero, db.Neg, db.Ovf}), 32'd0);
    rst_d = 1'b0;
    op_d(8'h12, 8'h34, 1'b0, 1'b0, lat);
    check("after_reset_latency", 32'(lat), 32'd2);
    check("after_reset_sum", 32'(db.Sum), 32'h46);
    @(negedge clk);

    go_rnd = 1'b1;
    for (int i = 0; i < 20000 && ndone < 3; i++) @(negedge clk);
    check("rnd_complete", 32'(ndone), 32'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
